aes_decrypt_wrapper: RTL and testbench
======================================

AES_DECRYPT_WRAPPER -- requirements
Module: aes_decrypt_wrapper

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 (Nk=4, Nr=10).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port key  input  128  cipher key; bits [127:120] = FIPS-197 byte 0.
REQ-006 Port data_in  input  128  ciphertext block, same byte order as key.
REQ-007 Port start  input  1  single-cycle request; key and data_in are sampled on the same edge.
REQ-008 Port decrypt_data_out  output  128  recovered plaintext, same byte order.
REQ-009 Port decrypt_data_out_rdy  output  1  level; high while decrypt_data_out is valid.
REQ-010 Port busy  output  1  high from the accepting edge until decrypt_data_out_rdy rises.

Function
REQ-011 The block SHALL implement the FSM states IDLE, KEYEXP, ADDKEY, ROUND, FINAL and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL latch key and data_in, clear decrypt_data_out_rdy, set busy, zero the round counter and enter KEYEXP.
REQ-013 KEYEXP SHALL run forward key expansion one round key per cycle for exactly 10 cycles (Rcon 01..36), ending with rk10 in the key register.
REQ-014 ADDKEY SHALL take 1 cycle: state := state XOR rk10; key register := rk9 by inverse key-schedule step.
REQ-015 ROUND SHALL take 9 cycles, each doing InvShiftRows, InvSubBytes, AddRoundKey(current rk), InvMixColumns, then stepping the key register back one round (rk9..rk1 consumed).
REQ-016 FINAL SHALL take 1 cycle: InvShiftRows, InvSubBytes, AddRoundKey(rk0), result registered into decrypt_data_out; the next state is DONE.
REQ-017 Latency SHALL be exactly 21 clock edges from the start-accepting edge to the edge that sets decrypt_data_out_rdy.
REQ-018 In DONE, decrypt_data_out and decrypt_data_out_rdy SHALL hold indefinitely until start or rst.
REQ-019 A start in DONE SHALL clear decrypt_data_out_rdy on the accepting edge (a back-to-back request).
REQ-020 The block SHALL ignore start while busy=1; the in-flight operation SHALL complete unaffected.
REQ-021 The inverse key step SHALL be w[i-4] = w[i] XOR w[i-1], with the first word using SubWord(RotWord(w[i-1])) XOR Rcon.
REQ-022 The round counter SHALL be 4 bits, SHALL never exceed 10, and SHALL index Rcon in both directions.
REQ-023 key and data_in changes outside the accepting edge SHALL have no effect.

Reset
REQ-024 On rst=1 at a clock edge: state SHALL go to IDLE, decrypt_data_out to 0, decrypt_data_out_rdy to 0, busy to 0, and the counter, key and state registers to 0.
REQ-025 rst SHALL override start on the same edge.
REQ-026 rst during any busy state SHALL abort the operation with no partial result visible.

Structure
REQ-027 The shared package aes_pkg SHALL hold the Nr constant, the Rcon table, the sbox and inv_sbox functions, the xtime/gf multiply functions and the FSM state enum type.
REQ-028 A single combinational sub-module, aes_inv_round, SHALL compute one inverse round with a bypass_mix input for FINAL; the key-schedule step SHALL stay inline.

Verification
REQ-029 Scenario: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> 00112233445566778899aabbccddeeff with rdy high exactly 21 cycles after start.
REQ-030 Scenario: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3ad77bb40d7a3660a89ecaf32466ef97 -> 6bc1bee22e409f96e93d7e117393172a.
REQ-031 Scenario: back-to-back requests; in DONE, start with key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> rdy drops on the accepting edge, then output 3243f6a8885a308d313198a2e0370734 after 21 cycles.
REQ-032 Scenario: start pulses and key/data_in changes while busy -> ignored; the result equals the original vector's plaintext.
REQ-033 Scenario: rst at cycle 12 of an operation -> all outputs 0 on the next edge; a fresh start then yields the correct plaintext.
REQ-034 Scenario: rst and start asserted on the same edge -> IDLE held, busy=0, rdy=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, Rcon, S-boxes, GF(2^8) arithmetic and FSM states.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYEXP,
    ST_ADDKEY,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] x;
    x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(x);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; i_bypass_mix drops InvMixColumns for the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_bypass_mix,
  output logic [127:0] o_state
);

  // Byte k of the block sits at row k%4, column k/4; element 0 is bits [127:120]
  logic [0:15][7:0] w_in;
  logic [0:15][7:0] w_sub;
  logic [0:15][7:0] w_ark;
  logic [0:15][7:0] w_mix;

  always_comb begin
    w_in  = i_state;
    w_sub = '0;
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sub[4*c+r] = inv_sbox(w_in[4*((c + 4 - r) % 4) + r]);
      end
    end
    w_ark = w_sub ^ i_round_key;
    for (int c = 0; c < 4; c++) begin
      w_mix[4*c+0] = gf_mul(w_ark[4*c+0], 8'h0e) ^ gf_mul(w_ark[4*c+1], 8'h0b) ^
                     gf_mul(w_ark[4*c+2], 8'h0d) ^ gf_mul(w_ark[4*c+3], 8'h09);
      w_mix[4*c+1] = gf_mul(w_ark[4*c+0], 8'h09) ^ gf_mul(w_ark[4*c+1], 8'h0e) ^
                     gf_mul(w_ark[4*c+2], 8'h0b) ^ gf_mul(w_ark[4*c+3], 8'h0d);
      w_mix[4*c+2] = gf_mul(w_ark[4*c+0], 8'h0d) ^ gf_mul(w_ark[4*c+1], 8'h09) ^
                     gf_mul(w_ark[4*c+2], 8'h0e) ^ gf_mul(w_ark[4*c+3], 8'h0b);
      w_mix[4*c+3] = gf_mul(w_ark[4*c+0], 8'h0b) ^ gf_mul(w_ark[4*c+1], 8'h0d) ^
                     gf_mul(w_ark[4*c+2], 8'h09) ^ gf_mul(w_ark[4*c+3], 8'h0e);
    end
    o_state = i_bypass_mix ? w_ark : w_mix;
  end

endmodule

// File: rtl/aes_decrypt_wrapper.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then one inverse round per cycle
// while the key register is walked back with the inverse key schedule.
module aes_decrypt_wrapper
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic [127:0] data_in,
  input  logic         start,
  output logic [127:0] decrypt_data_out,
  output logic         decrypt_data_out_rdy,
  output logic         busy
);

  state_e       r_fsm;
  state_e       w_fsm_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_key;
  logic [127:0] r_blk;
  logic [127:0] r_out;
  logic         r_rdy;
  logic         r_busy;

  logic         w_load;
  logic         w_kexp;
  logic         w_addkey;
  logic         w_round;
  logic         w_final;
  logic [127:0] w_round_out;

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo key_fwd: the last three words first, then the first word from the recovered w3
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  aes_inv_round u_inv_round (
    .i_state     (r_blk),
    .i_round_key (r_key),
    .i_bypass_mix(w_final),
    .o_state     (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) r_fsm <= ST_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      ST_IDLE:   if (start) w_fsm_nxt = ST_KEYEXP;
      ST_KEYEXP: if (r_cnt == 4'(NR - 1)) w_fsm_nxt = ST_ADDKEY;
      ST_ADDKEY: w_fsm_nxt = ST_ROUND;
      ST_ROUND:  if (r_cnt == 4'd1) w_fsm_nxt = ST_FINAL;
      ST_FINAL:  w_fsm_nxt = ST_DONE;
      ST_DONE:   if (start) w_fsm_nxt = ST_KEYEXP;
      default:   w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_kexp   = 1'b0;
    w_addkey = 1'b0;
    w_round  = 1'b0;
    w_final  = 1'b0;
    unique case (r_fsm)
      ST_IDLE:   w_load   = start;
      ST_KEYEXP: w_kexp   = 1'b1;
      ST_ADDKEY: w_addkey = 1'b1;
      ST_ROUND:  w_round  = 1'b1;
      ST_FINAL:  w_final  = 1'b1;
      ST_DONE:   w_load   = start;
      default:   w_load   = 1'b0;
    endcase
  end

  // Datapath: r_cnt counts up to NR during expansion and back down to 0 through the rounds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_key  <= '0;
      r_blk  <= '0;
      r_out  <= '0;
      r_rdy  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      if (w_load) begin
        r_key  <= key;
        r_blk  <= data_in;
        r_cnt  <= 4'd0;
        r_rdy  <= 1'b0;
        r_busy <= 1'b1;
      end
      if (w_kexp) begin
        r_key <= key_fwd(r_key, rcon(r_cnt + 4'd1));
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_addkey) begin
        r_blk <= r_blk ^ r_key;
        r_key <= key_inv(r_key, rcon(r_cnt));
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_round) begin
        r_blk <= w_round_out;
        r_key <= key_inv(r_key, rcon(r_cnt));
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_final) begin
        r_out  <= w_round_out;
        r_rdy  <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign decrypt_data_out     = r_out;
  assign decrypt_data_out_rdy = r_rdy;
  assign busy                 = r_busy;

endmodule

// File: tb/tb_aes_decrypt_wrapper.sv
// Scoreboard bench for aes_decrypt_wrapper using FIPS-197 / SP800-38A known-answer vectors.
module tb_aes_decrypt_wrapper;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] data_in;
  logic [127:0] decrypt_data_out;
  logic         decrypt_data_out_rdy;
  logic         busy;

  always #5 clk = ~clk;

  aes_decrypt_wrapper dut (
    .clk                 (clk),
    .rst                 (rst),
    .key                 (key),
    .data_in             (data_in),
    .start               (start),
    .decrypt_data_out    (decrypt_data_out),
    .decrypt_data_out_rdy(decrypt_data_out_rdy),
    .busy                (busy)
  );

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C3 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           c0;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic rdy_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of rdy must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (decrypt_data_out_rdy && !rdy_d) begin
      if (q.size() == 0) begin
        chk("unexpected_rdy", {127'd0, decrypt_data_out_rdy}, 128'd0);
      end else begin
        e = q.pop_front();
        chk("plaintext", decrypt_data_out, e.pt);
        chk("latency", 128'(cyc - e.c0), 128'd21);
        chk("busy_at_rdy", {127'd0, busy}, 128'd0);
      end
    end
    rdy_d = decrypt_data_out_rdy;
  end

  task automatic start_op(input logic [127:0] k, input logic [127:0] d,
                          input logic [127:0] pt, input bit expect_accept);
    @(posedge clk);
    #1;
    key     = k;
    data_in = d;
    start   = 1'b1;
    if (expect_accept) q.push_back('{pt: pt, c0: cyc + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      chk("timeout_pending", 128'(q.size()), 128'd0);
      q.delete();
    end
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    key     = '0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", decrypt_data_out, 128'd0);
    chk("reset_rdy", {127'd0, decrypt_data_out_rdy}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;

    // FIPS-197 appendix C.1 vector
    start_op(K1, C1, P1, 1'b1);
    chk("busy_after_accept", {127'd0, busy}, 128'd1);
    wait_done(60);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_out", decrypt_data_out, P1);
    chk("hold_rdy", {127'd0, decrypt_data_out_rdy}, 128'd1);

    // SP800-38A ECB block, then a back-to-back request issued from DONE
    start_op(K2, C2, P2, 1'b1);
    wait_done(60);
    start_op(K2, C3, P3, 1'b1);
    chk("b2b_rdy_drop", {127'd0, decrypt_data_out_rdy}, 128'd0);
    chk("b2b_busy", {127'd0, busy}, 128'd1);
    wait_done(60);

    // Starts and input changes while busy must be ignored
    start_op(K1, C1, P1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b1;
    key     = K2;
    data_in = C2;
    @(posedge clk);
    #1;
    start   = 1'b0;
    key     = 128'hdeadbeef_01234567_89abcdef_fedcba98;
    data_in = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    repeat (12) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(60);

    // Abort with rst mid-operation, then a clean run
    start_op(K2, C2, P2, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("abort_out", decrypt_data_out, 128'd0);
    chk("abort_rdy", {127'd0, decrypt_data_out_rdy}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_rdy", {127'd0, decrypt_data_out_rdy}, 128'd0);
    start_op(K2, C2, P2, 1'b1);
    wait_done(60);

    // rst wins over start on the same edge
    @(posedge clk);
    #1;
    rst     = 1'b1;
    start   = 1'b1;
    key     = K1;
    data_in = C1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {127'd0, busy}, 128'd0);
    chk("rst_start_rdy", {127'd0, decrypt_data_out_rdy}, 128'd0);
    chk("rst_start_out", decrypt_data_out, 128'd0);
    @(posedge clk);
    #1;
    chk("rst_start_idle", {127'd0, busy}, 128'd0);
    repeat (30) @(posedge clk);
    #1;
    chk("rst_start_no_rdy", {127'd0, decrypt_data_out_rdy}, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
